// File: rtl/frame_former_scheduler.sv
// Round-robin scheduler sharing one frame former between NUM_CH show-ahead payload FIFOs.
// A channel is admitted only once its FIFO already holds a whole frame of payload.
module frame_former_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 12,
  parameter int DATA_W = 64
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [NUM_CH*CNT_W-1:0]  ch_count,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_rd_en,
  input  logic [NUM_CH-1:0]        cfg_enable,
  input  logic [NUM_CH*48-1:0]     cfg_dest_addr,
  input  logic [NUM_CH*16-1:0]     cfg_sync_word,
  input  logic [13:0]              cfg_packet_size,
  output logic                     ffm_is_empty,
  input  logic                     ffm_ready,
  output logic [DATA_W-1:0]        ffm_data,
  output logic [47:0]              ffm_dest_addr,
  output logic [15:0]              ffm_sync_word,
  output logic [13:0]              ffm_packet_size,
  input  logic [13:0]              ffm_state,
  input  logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  input  logic                     m_axis_tlast,
  output logic [2:0]               grant_id,
  output logic                     busy,
  output logic [15:0]              frame_count,
  output logic                     err_underrun,
  output logic                     err_cfg
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARB    = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int         CMP_W   = (CNT_W > 14) ? CNT_W : 14;
  localparam logic [2:0] RR_INIT = 3'(NUM_CH - 1);

  logic [2:0]  state_q, state_d;
  logic [2:0]  rr_q, rr_d;
  logic [2:0]  grant_q, grant_d;
  logic [47:0] dest_q, dest_d;
  logic [15:0] sync_q, sync_d;
  logic [13:0] psize_q, psize_d;
  logic [13:0] beats_q, beats_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic        err_ur_q, err_ur_d;
  logic        err_cfg_q, err_cfg_d;
  logic        busy_q, busy_d;

  logic [13:0] need_s;
  logic        size_ok_s;
  logic [7:0]  elig_s;
  logic        found_s;
  logic [2:0]  pick_s;
  logic [7:0]  rd_full_s;
  logic        tlast_hs_s;

  function automatic logic [2:0] rr_idx(input logic [2:0] base, input int k);
    rr_idx = 3'((int'(base) + k) % NUM_CH);
  endfunction

  // Eligibility per channel and round-robin search starting just after the last grant
  always_comb begin
    need_s    = cfg_packet_size - 14'd2;
    size_ok_s = (cfg_packet_size >= 14'd3);
    elig_s    = 8'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      elig_s[i] = cfg_enable[i] & size_ok_s &
                  (CMP_W'(ch_count[i*CNT_W +: CNT_W]) >= CMP_W'(need_s));
    end
    found_s = 1'b0;
    pick_s  = 3'd0;
    // Walk from farthest to nearest so the nearest eligible channel wins.
    for (int k = NUM_CH; k >= 1; k--) begin
      found_s = found_s | elig_s[rr_idx(rr_q, k)];
      pick_s  = elig_s[rr_idx(rr_q, k)] ? rr_idx(rr_q, k) : pick_s;
    end
  end

  assign tlast_hs_s = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  // Next-state logic for the scheduler FSM and all per-frame registers
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    grant_d   = grant_q;
    dest_d    = dest_q;
    sync_d    = sync_q;
    psize_d   = psize_q;
    beats_d   = beats_q;
    fcnt_d    = fcnt_q;
    err_ur_d  = err_ur_q;
    err_cfg_d = err_cfg_q;
    busy_d    = busy_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_ARB;
      end
      S_ARB: begin
        if (!size_ok_s) begin
          err_cfg_d = 1'b1;
        end else if (found_s) begin
          grant_d = pick_s;
          rr_d    = pick_s;
          dest_d  = cfg_dest_addr[pick_s*48 +: 48];
          sync_d  = cfg_sync_word[pick_s*16 +: 16];
          psize_d = cfg_packet_size;
          beats_d = need_s;
          busy_d  = 1'b1;
          state_d = S_LAUNCH;
        end else begin
          state_d = S_ARB;
        end
      end
      S_LAUNCH: begin
        // A tlast seen here cannot belong to this frame; the former is still in state 0.
        if (ffm_state != 14'd0) begin
          state_d = S_RUN;
        end else begin
          state_d = S_LAUNCH;
        end
      end
      S_RUN: begin
        if (ffm_ready && (beats_q != 14'd0)) begin
          beats_d = beats_q - 14'd1;
        end else if (ffm_ready) begin
          err_ur_d = 1'b1;
        end else begin
          beats_d = beats_q;
        end
        if (tlast_hs_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        fcnt_d  = fcnt_q + 16'd1;
        busy_d  = 1'b0;
        state_d = S_ARB;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Payload steering and launch request toward the shared former
  always_comb begin
    rd_full_s = 8'd0;
    if ((state_q == S_RUN) && ffm_ready && (beats_q != 14'd0)) begin
      rd_full_s[grant_q] = 1'b1;
    end else begin
      rd_full_s = 8'd0;
    end
    ch_rd_en     = rd_full_s[NUM_CH-1:0];
    ffm_data     = ch_data[grant_q*DATA_W +: DATA_W];
    ffm_is_empty = !((state_q == S_LAUNCH) && (ffm_state == 14'd0));
  end

  // State registers with synchronous reset
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= S_IDLE;
      rr_q      <= RR_INIT;
      grant_q   <= 3'd0;
      dest_q    <= 48'd0;
      sync_q    <= 16'd0;
      psize_q   <= 14'd0;
      beats_q   <= 14'd0;
      fcnt_q    <= 16'd0;
      err_ur_q  <= 1'b0;
      err_cfg_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      dest_q    <= dest_d;
      sync_q    <= sync_d;
      psize_q   <= psize_d;
      beats_q   <= beats_d;
      fcnt_q    <= fcnt_d;
      err_ur_q  <= err_ur_d;
      err_cfg_q <= err_cfg_d;
      busy_q    <= busy_d;
    end
  end

  assign ffm_dest_addr   = dest_q;
  assign ffm_sync_word   = sync_q;
  assign ffm_packet_size = psize_q;
  assign grant_id        = grant_q;
  assign busy            = busy_q;
  assign frame_count     = fcnt_q;
  assign err_underrun    = err_ur_q;
  assign err_cfg         = err_cfg_q;

endmodule

// File: tb/tb_frame_former_scheduler.sv
// Bench for frame_former_scheduler: emulates a frame former (2 header beats, payload, tlast)
// and per-channel FIFOs, and predicts grants/pops from the round-robin admission rules.
module tb_frame_former_scheduler;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 12;
  localparam int DATA_W = 64;

  logic                     ACLK;
  logic                     ARESET;
  logic [NUM_CH*CNT_W-1:0]  ch_count;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_rd_en;
  logic [NUM_CH-1:0]        cfg_enable;
  logic [NUM_CH*48-1:0]     cfg_dest_addr;
  logic [NUM_CH*16-1:0]     cfg_sync_word;
  logic [13:0]              cfg_packet_size;
  logic                     ffm_is_empty;
  logic                     ffm_ready;
  logic [DATA_W-1:0]        ffm_data;
  logic [47:0]              ffm_dest_addr;
  logic [15:0]              ffm_sync_word;
  logic [13:0]              ffm_packet_size;
  logic [13:0]              ffm_state;
  logic                     m_axis_tvalid;
  logic                     m_axis_tready;
  logic                     m_axis_tlast;
  logic [2:0]               grant_id;
  logic                     busy;
  logic [15:0]              frame_count;
  logic                     err_underrun;
  logic                     err_cfg;

  frame_former_scheduler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .ch_count(ch_count), .ch_data(ch_data), .ch_rd_en(ch_rd_en),
    .cfg_enable(cfg_enable), .cfg_dest_addr(cfg_dest_addr), .cfg_sync_word(cfg_sync_word),
    .cfg_packet_size(cfg_packet_size), .ffm_is_empty(ffm_is_empty), .ffm_ready(ffm_ready),
    .ffm_data(ffm_data), .ffm_dest_addr(ffm_dest_addr), .ffm_sync_word(ffm_sync_word),
    .ffm_packet_size(ffm_packet_size), .ffm_state(ffm_state), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .grant_id(grant_id), .busy(busy),
    .frame_count(frame_count), .err_underrun(err_underrun), .err_cfg(err_cfg)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int          n_vec, n_err;
  int          cnt [NUM_CH];
  int          seq [NUM_CH];
  logic [31:0] salt [NUM_CH];
  int          f_phase, f_hdr, f_pay, f_extra, tr_mode;
  logic        tr;
  int          m_rr, m_fc, m_grant, m_left, pops_frame, low_cycles, done_cnt;
  bit          in_frame;
  logic [47:0] m_dest, old_dest, new_dest;
  logic [15:0] m_sync;
  logic [13:0] m_psize;
  int          g_log [$];
  int          base [NUM_CH];
  int          lat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] head(input int ch, input int s);
    return {salt[ch], 32'(s) ^ (32'(ch) << 28)};
  endfunction

  // Round-robin admission: first enabled channel after the last grant holding a full payload.
  function automatic int pick();
    int need;
    if (cfg_packet_size < 14'd3) return -1;
    need = int'(cfg_packet_size) - 2;
    for (int k = 1; k <= NUM_CH; k++) begin
      int c;
      c = (m_rr + k) % NUM_CH;
      if (cfg_enable[c] && cnt[c] >= need) return c;
    end
    return -1;
  endfunction

  task automatic drive_fifos();
    for (int i = 0; i < NUM_CH; i++) begin
      ch_count[i*CNT_W +: CNT_W]   = 12'(cnt[i]);
      ch_data[i*DATA_W +: DATA_W]  = head(i, seq[i]);
    end
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    ffm_ready = 1'b0; m_axis_tvalid = 1'b0; m_axis_tlast = 1'b0; m_axis_tready = 1'b1;
    ffm_state = 14'd0;
    drive_fifos();
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    f_phase = 0; in_frame = 0; m_rr = NUM_CH - 1; m_fc = 0; done_cnt = 0;
  endtask

  task automatic check_reset();
    ffm_ready = 1'b0; m_axis_tvalid = 1'b0; m_axis_tlast = 1'b0; ffm_state = 14'd0;
    drive_fifos();
    @(negedge ACLK);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rd_en", 64'(ch_rd_en), 64'd0);
    chk("rst_is_empty", 64'(ffm_is_empty), 64'd1);
    chk("rst_frame_count", 64'(frame_count), 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
    chk("rst_err_underrun", 64'(err_underrun), 64'd0);
    chk("rst_err_cfg", 64'(err_cfg), 64'd0);
    chk("rst_dest", 64'(ffm_dest_addr), 64'd0);
    chk("rst_sync", 64'(ffm_sync_word), 64'd0);
    chk("rst_psize", 64'(ffm_packet_size), 64'd0);
    @(posedge ACLK); #1;
  endtask

  // One clock: former emulation, FIFO model, per-cycle and per-frame checks.
  task automatic cyc();
    logic [NUM_CH-1:0] rd_s, exp_rd;
    logic              empty_s, hs;
    logic [13:0]       ps_s;
    int                p;
    case (tr_mode)
      0:       tr = 1'b1;
      1:       tr = ~tr;
      default: tr = 1'($urandom_range(0, 1));
    endcase
    m_axis_tready = tr;
    ffm_state     = 14'(f_phase);
    ffm_ready     = (f_phase == 2) && tr;
    m_axis_tvalid = (f_phase != 0);
    m_axis_tlast  = (f_phase == 3);
    drive_fifos();
    @(negedge ACLK);
    empty_s = ffm_is_empty; rd_s = ch_rd_en; ps_s = ffm_packet_size;
    if (!empty_s && !in_frame) begin
      p = pick();
      chk("grant", 64'(grant_id), 64'(p));
      chk("busy_launch", 64'(busy), 64'd1);
      m_grant   = (p < 0) ? (int'(grant_id) % NUM_CH) : p;
      m_psize   = cfg_packet_size;
      m_dest    = cfg_dest_addr[m_grant*48 +: 48];
      m_sync    = cfg_sync_word[m_grant*16 +: 16];
      m_left    = int'(cfg_packet_size) - 2;
      m_rr      = m_grant;
      in_frame  = 1; pops_frame = 0; low_cycles = 0;
      g_log.push_back(m_grant);
    end
    if (in_frame) begin
      chk("lat_dest", 64'(ffm_dest_addr), 64'(m_dest));
      chk("lat_sync", 64'(ffm_sync_word), 64'(m_sync));
      chk("lat_psize", 64'(ffm_packet_size), 64'(m_psize));
    end
    if (!empty_s) low_cycles++;
    exp_rd = '0;
    if (in_frame && ffm_ready && m_left > 0) exp_rd[m_grant] = 1'b1;
    chk("rd_en", 64'(rd_s), 64'(exp_rd));
    if (exp_rd != '0) chk("ffm_data", ffm_data, head(m_grant, seq[m_grant]));
    if (in_frame) pops_frame += int'(rd_s[m_grant]);
    if (done_cnt == 1) begin
      chk("frame_count", 64'(frame_count), 64'(16'(m_fc)));
      chk("busy_after_done", 64'(busy), 64'd0);
    end
    hs = m_axis_tvalid & m_axis_tready & m_axis_tlast;
    @(posedge ACLK); #1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_s[i]) begin seq[i]++; cnt[i]--; end
    end
    if (exp_rd != '0) m_left--;
    if (done_cnt > 0) done_cnt--;
    case (f_phase)
      0: if (!empty_s && tr) begin f_phase = 1; f_hdr = 2; f_pay = int'(ps_s) - 2 + f_extra; end
      1: if (tr) begin f_hdr--; if (f_hdr == 0) f_phase = 2; end
      2: if (tr) begin f_pay--; if (f_pay == 0) f_phase = 3; end
      default: if (tr) f_phase = 0;
    endcase
    if (hs && in_frame) begin
      chk("frame_pops", 64'(pops_frame), 64'(int'(m_psize) - 2));
      if (tr_mode == 0) chk("start_low_cycles", 64'(low_cycles), 64'd1);
      m_fc++; done_cnt = 2; in_frame = 0;
    end
  endtask

  task automatic run_until(input int target, input int budget);
    int n;
    n = 0;
    while (m_fc < target && n < budget) begin cyc(); n++; end
    chk("frames_done", 64'(m_fc), 64'(target));
  endtask

  initial begin
    n_vec = 0; n_err = 0; tr = 1'b1; tr_mode = 0; f_extra = 0; f_phase = 0;
    in_frame = 0; done_cnt = 0; m_rr = NUM_CH - 1; m_fc = 0; m_grant = 0; m_left = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      salt[i] = $urandom; cnt[i] = 0; seq[i] = 0;
      cfg_dest_addr[i*48 +: 48] = {16'($urandom), $urandom};
      cfg_sync_word[i*16 +: 16] = 16'($urandom);
    end
    cfg_enable = 4'hF;
    cfg_packet_size = 14'd6;
    do_reset(); check_reset();

    // 1: single frame of 4 payload words from channel 0
    cnt[0] = 4;
    run_until(1, 100);
    chk("t1_grant", 64'(g_log[0]), 64'd0);
    chk("t1_pops", 64'(seq[0]), 64'd4);
    cyc(); cyc();

    // 2: all channels loaded -> grants 0,1,2,3,0 with 8 pops each
    do_reset(); check_reset(); g_log.delete();
    cfg_packet_size = 14'd10;
    for (int i = 0; i < NUM_CH; i++) begin cnt[i] = 100; base[i] = seq[i]; end
    run_until(5, 400);
    chk("t2_n_grants", 64'(g_log.size()), 64'd5);
    for (int i = 0; i < 5; i++) chk("t2_order", 64'(g_log[i]), 64'(i % NUM_CH));
    chk("t2_pops_ch0", 64'(seq[0] - base[0]), 64'd16);
    for (int i = 1; i < NUM_CH; i++) chk("t2_pops_chn", 64'(seq[i] - base[i]), 64'd8);

    // 3: one word short holds off admission; topping up grants within 2 cycles
    for (int i = 0; i < NUM_CH; i++) cnt[i] = 0;
    cnt[1] = 7;
    for (int n = 0; n < 8; n++) begin cyc(); chk("t3_hold_empty", 64'(ffm_is_empty), 64'd1); end
    cnt[1] = 8; lat = 0;
    while (!in_frame && lat < 6) begin cyc(); lat++; end
    chk("t3_latency_ok", 64'(lat <= 2), 64'd1);
    chk("t3_grant", 64'(grant_id), 64'd1);
    run_until(m_fc + 1, 200);

    // 4: back-pressured frame, then random back-pressure/enables/sizes
    tr_mode = 1; cnt[2] = 30;
    cfg_packet_size = 14'($urandom_range(5, 12));
    run_until(m_fc + 1, 300);
    chk("t4_no_underrun", 64'(err_underrun), 64'd0);
    tr_mode = 2;
    cfg_enable = 4'($urandom_range(1, 15));
    cfg_packet_size = 14'($urandom_range(3, 12));
    for (int i = 0; i < NUM_CH; i++) cnt[i] = $urandom_range(50, 90);
    run_until(m_fc + 4, 800);
    chk("t4_no_underrun_rand", 64'(err_underrun), 64'd0);
    tr_mode = 0; cfg_enable = 4'hF;

    // 5: config changes mid-frame apply only to the next grant
    for (int i = 0; i < NUM_CH; i++) cnt[i] = 0;
    cnt[0] = 50; cfg_packet_size = 14'd8;
    for (int n = 0; n < 60 && f_phase != 2; n++) cyc();
    old_dest = cfg_dest_addr[47:0];
    new_dest = old_dest ^ 48'hFFFF_0000_FFFF;
    cfg_dest_addr[47:0] = new_dest;
    cfg_packet_size = 14'd5;
    cyc();
    chk("t5_hold_dest", 64'(ffm_dest_addr), 64'(old_dest));
    chk("t5_hold_psize", 64'(ffm_packet_size), 64'd8);
    run_until(m_fc + 1, 200);
    for (int n = 0; n < 20 && !in_frame; n++) cyc();
    chk("t5_new_grant", 64'(grant_id), 64'd0);
    chk("t5_new_dest", 64'(ffm_dest_addr), 64'(new_dest));
    chk("t5_new_psize", 64'(ffm_packet_size), 64'd5);
    run_until(m_fc + 1, 200);

    // 6: reset in RUN with 3 beats left, then first grant goes to channel 0
    cfg_packet_size = 14'd10; cnt[0] = 40; cnt[3] = 40;
    for (int n = 0; n < 200 && !(in_frame && f_phase == 2 && m_left == 3); n++) cyc();
    chk("t6_reached_3_left", 64'(m_left), 64'd3);
    do_reset(); check_reset();
    run_until(1, 100);
    chk("t6_first_grant", 64'(g_log[$]), 64'd0);

    // packet size below 3 flags a config error and grants nothing
    cfg_packet_size = 14'd2;
    for (int n = 0; n < 6; n++) begin cyc(); chk("cfg_no_launch", 64'(ffm_is_empty), 64'd1); end
    chk("err_cfg_set", 64'(err_cfg), 64'd1);

    // an extra payload read from the former raises underrun without popping
    cfg_packet_size = 14'd6; f_extra = 1;
    run_until(m_fc + 1, 200);
    f_extra = 0;
    chk("err_underrun_set", 64'(err_underrun), 64'd1);

    do_reset(); check_reset();
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
